// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Six-digit multiplexed 7-segment display scanner. Takes a
//            per-frame snapshot of six hex digits plus dp/blink masks and
//            the leading-zero-suppression enable. It then time-multiplexes
//            them onto a shared segment bus. Each digit slot opens with a
//            dead-time window in which every digit is disabled, which keeps
//            the previous digit's segments from ghosting onto the next one.
// Ports    : clk          - system clock (single domain)
//            rst          - asynchronous reset, active-high
//            i_digit      - six 4-bit digits, [3:0] = digit 0 (rightmost)
//            i_dp_mask    - bit k lights the decimal point of digit k
//            i_blink_mask - bit k makes digit k blink
//            i_lzs        - 1 enables leading-zero suppression
//            o_seg        - segments {g,f,e,d,c,b,a}, 1 = lit
//            o_seg_dp     - decimal point, 1 = lit
//            o_seg_enb    - digit enables, active-low one-cold
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,  // clocks per digit slot (>= 4)
  parameter int DEAD_CYC  = 2500,   // blanked clocks at slot start (< SCAN_DIV)
  parameter int BLINK_DIV = 500     // slots per blink half-period (>= 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_digit,
  input  logic [5:0]  i_dp_mask,
  input  logic [5:0]  i_blink_mask,
  input  logic        i_lzs,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYC);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0]    SLOT_LAST = 3'd5;
  localparam logic [5:0]    ENB_NONE  = 6'h3F;

  // --------------------------------------------------------------------------
  // Scan state
  // --------------------------------------------------------------------------
  logic [PW-1:0] pcnt;        // clock position inside the current slot
  logic [2:0]    idx;         // slot index 0..5 = digit being driven
  logic [BW-1:0] bcnt;        // slot ticks inside the current blink phase
  logic          blink_ph;    // 1 = blinking digits are dark

  // Frame snapshot of every input
  logic [23:0]   snap_digit;
  logic [5:0]    snap_dp;
  logic [5:0]    snap_blink;
  logic          snap_lzs;

  logic          slot_tick;   // last clock of a slot
  logic          frame_wrap;  // last clock of slot 5 -> new frame begins
  logic          blink_tc;    // last slot of a blink half-period

  assign slot_tick  = (pcnt == PCNT_LAST);
  assign frame_wrap = slot_tick && (idx == SLOT_LAST);
  assign blink_tc   = slot_tick && (bcnt == BCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (slot_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (frame_wrap) begin
      idx <= 3'd0;
    end else if (slot_tick) begin
      idx <= idx + 3'd1;
    end
  end

  // The blink phase can flip on the same clock as a frame wrap; both
  // registers update together, so the new frame starts with the new phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (blink_tc) begin
      bcnt     <= '0;
      blink_ph <= ~blink_ph;
    end else if (slot_tick) begin
      bcnt     <= bcnt + 1'b1;
    end
  end

  // Inputs are captured once per frame only, so a count that changes
  // mid-scan can never show half old / half new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digit <= '0;
      snap_dp    <= '0;
      snap_blink <= '0;
      snap_lzs   <= 1'b0;
    end else if (frame_wrap) begin
      snap_digit <= i_digit;
      snap_dp    <= i_dp_mask;
      snap_blink <= i_blink_mask;
      snap_lzs   <= i_lzs;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression
  // zero_run[k] = digit k and every digit above it are zero. Digit 0 is
  // never suppressed so a value of zero still shows a single "0".
  // --------------------------------------------------------------------------
  logic [5:1] digit_zero;
  logic [5:1] zero_run;
  logic [5:0] lzs_blank;

  assign lzs_blank[0] = 1'b0;

  for (genvar k = 1; k < 6; k++) begin : g_lzs
    assign digit_zero[k] = (snap_digit[4*k +: 4] == 4'h0);
    if (k == 5) begin : g_top
      assign zero_run[k] = digit_zero[k];
    end else begin : g_chain
      assign zero_run[k] = digit_zero[k] & zero_run[k+1];
    end
    assign lzs_blank[k] = snap_lzs & zero_run[k];
  end

  // --------------------------------------------------------------------------
  // Slot selection: everything belonging to the digit of the current slot.
  // Unused index values fall back to slot 0, so the enable stays one-cold.
  // --------------------------------------------------------------------------
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_blink;
  logic       cur_lzs;
  logic [5:0] cur_enb;

  always_comb begin
    cur_digit = snap_digit[3:0];
    cur_dp    = snap_dp[0];
    cur_blink = snap_blink[0];
    cur_lzs   = lzs_blank[0];
    cur_enb   = 6'b111110;
    case (idx)
      3'd1: begin
        cur_digit = snap_digit[7:4];
        cur_dp    = snap_dp[1];
        cur_blink = snap_blink[1];
        cur_lzs   = lzs_blank[1];
        cur_enb   = 6'b111101;
      end
      3'd2: begin
        cur_digit = snap_digit[11:8];
        cur_dp    = snap_dp[2];
        cur_blink = snap_blink[2];
        cur_lzs   = lzs_blank[2];
        cur_enb   = 6'b111011;
      end
      3'd3: begin
        cur_digit = snap_digit[15:12];
        cur_dp    = snap_dp[3];
        cur_blink = snap_blink[3];
        cur_lzs   = lzs_blank[3];
        cur_enb   = 6'b110111;
      end
      3'd4: begin
        cur_digit = snap_digit[19:16];
        cur_dp    = snap_dp[4];
        cur_blink = snap_blink[4];
        cur_lzs   = lzs_blank[4];
        cur_enb   = 6'b101111;
      end
      3'd5: begin
        cur_digit = snap_digit[23:20];
        cur_dp    = snap_dp[5];
        cur_blink = snap_blink[5];
        cur_lzs   = lzs_blank[5];
        cur_enb   = 6'b011111;
      end
      default: begin
      end
    endcase
  end

  // Hex to 7-segment, {g,f,e,d,c,b,a}, lowercase b and d.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Next output values
  // A blink-dark digit loses its dp as well; an LZS-blanked digit keeps its
  // dp so a suppressed position can still carry a decimal point.
  // --------------------------------------------------------------------------
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [5:0] enb_nxt;

  always_comb begin
    seg_nxt = 7'h00;
    dp_nxt  = 1'b0;
    enb_nxt = ENB_NONE;
    if (pcnt >= DEAD_END) begin
      enb_nxt = cur_enb;
      if (!(blink_ph && cur_blink)) begin
        dp_nxt = cur_dp;
        if (!cur_lzs) begin
          seg_nxt = seg_decode(cur_digit);
        end
      end
    end
  end

  // Registered outputs: clean pin timing, one clock behind the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_seg     <= 7'h00;
      o_seg_dp  <= 1'b0;
      o_seg_enb <= ENB_NONE;
    end else begin
      o_seg     <= seg_nxt;
      o_seg_dp  <= dp_nxt;
      o_seg_enb <= enb_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Directed self-checking bench for disp_scan_ctrl with
//            SCAN_DIV=8, DEAD_CYC=2, BLINK_DIV=4. Cycle n counts clock edges
//            after reset release; the outputs seen after edge n reflect
//            pcnt=(n-1)%8, slot=((n-1)/8)%6, frame=(n-1)/48, and
//            blink phase=((n-1)/32)%2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 4;

  logic        clk;
  logic        rst;
  logic [23:0] i_digit;
  logic [5:0]  i_dp_mask;
  logic [5:0]  i_blink_mask;
  logic        i_lzs;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic [5:0]  o_seg_enb;

  int passed = 0;
  int total  = 0;

  disp_scan_ctrl #(
    .SCAN_DIV  (SD),
    .DEAD_CYC  (DC),
    .BLINK_DIV (BD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_digit      (i_digit),
    .i_dp_mask    (i_dp_mask),
    .i_blink_mask (i_blink_mask),
    .i_lzs        (i_lzs),
    .o_seg        (o_seg),
    .o_seg_dp     (o_seg_dp),
    .o_seg_enb    (o_seg_enb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pc(input int n);
    return (n - 1) % SD;
  endfunction
  function automatic int sl(input int n);
    return ((n - 1) / SD) % 6;
  endfunction
  function automatic int fr(input int n);
    return (n - 1) / (6 * SD);
  endfunction
  function automatic int bp(input int n);
    return ((n - 1) / (SD * BD)) % 2;
  endfunction
  function automatic bit en(input int n);
    return pc(n) >= DC;
  endfunction
  function automatic logic [5:0] exp_enb(input int n);
    logic [5:0] e;
    e = 6'h3F;
    if (en(n)) e[sl(n)] = 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input int n,
                       input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [6:0] t2_seg [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
  logic [6:0] t4_seg [6] = '{7'h6D, 7'h3F, 7'h06, 7'h00, 7'h00, 7'h00};
  logic       t4_dp  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst          = 1'b1;
    i_digit      = 24'h0;
    i_dp_mask    = 6'h0;
    i_blink_mask = 6'h0;
    i_lzs        = 1'b0;

    // ---------------- 1: reset values and release timing ----------------
    step();
    check("rst_seg", 0, 32'(o_seg), 32'h00);
    check("rst_dp",  0, 32'(o_seg_dp), 32'h0);
    check("rst_enb", 0, 32'(o_seg_enb), 32'h3F);
    rst = 1'b0;
    step();
    check("rel_enb_c1", 1, 32'(o_seg_enb), 32'h3F);
    step();
    check("rel_enb_c2", 2, 32'(o_seg_enb), 32'h3F);
    step();
    check("rel_enb_c3", 3, 32'(o_seg_enb), 32'h3E);
    check("rel_seg_c3", 3, 32'(o_seg), 32'h3F);
    step();
    check("pre_async_enb", 4, 32'(o_seg_enb), 32'h3E);
    // Reset mid-slot, checked before any further clock edge
    rst = 1'b1;
    #1;
    check("async_seg", 4, 32'(o_seg), 32'h00);
    check("async_dp",  4, 32'(o_seg_dp), 32'h0);
    check("async_enb", 4, 32'(o_seg_enb), 32'h3F);
    step();
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      check("rerel_enb", n, 32'(o_seg_enb), 32'(exp_enb(n)));
    end

    // ---------------- 2: scan and decode ----------------
    i_digit = 24'h123456;
    pulse_reset();
    for (int n = 1; n <= 96; n++) begin
      step();
      check("t2_enb", n, 32'(o_seg_enb), 32'(exp_enb(n)));
      if (fr(n) == 0)
        check("t2_f0_seg", n, 32'(o_seg), en(n) ? 32'h3F : 32'h00);
      else
        check("t2_seg", n, 32'(o_seg), en(n) ? 32'(t2_seg[sl(n)]) : 32'h00);
      check("t2_dp", n, 32'(o_seg_dp), 32'h0);
    end

    // ---------------- 3: snapshot isolation ----------------
    i_digit = 24'h111111;
    pulse_reset();
    for (int n = 1; n <= 144; n++) begin
      step();
      if (n >= 49)
        check("t3_seg", n, 32'(o_seg),
              en(n) ? ((n <= 96) ? 32'h06 : 32'h5B) : 32'h00);
      if (n == 68) i_digit = 24'h222222;
    end

    // ---------------- 4: LZS + decimal point ----------------
    i_digit   = 24'h000105;
    i_lzs     = 1'b1;
    i_dp_mask = 6'b100001;
    pulse_reset();
    for (int n = 1; n <= 96; n++) begin
      step();
      if (fr(n) == 1) begin
        check("t4_seg", n, 32'(o_seg), en(n) ? 32'(t4_seg[sl(n)]) : 32'h00);
        check("t4_dp",  n, 32'(o_seg_dp), en(n) ? 32'(t4_dp[sl(n)]) : 32'h0);
      end
    end

    // ---------------- 5: blink ----------------
    i_digit      = 24'h000088;
    i_lzs        = 1'b0;
    i_dp_mask    = 6'b000011;
    i_blink_mask = 6'b000001;
    pulse_reset();
    for (int n = 1; n <= 240; n++) begin
      step();
      if (fr(n) >= 1 && en(n)) begin
        if (sl(n) == 0) begin
          check("t5_seg0", n, 32'(o_seg), (bp(n) != 0) ? 32'h00 : 32'h7F);
          check("t5_dp0",  n, 32'(o_seg_dp), (bp(n) != 0) ? 32'h0 : 32'h1);
        end else if (sl(n) == 1) begin
          check("t5_seg1", n, 32'(o_seg), 32'h7F);
          check("t5_dp1",  n, 32'(o_seg_dp), 32'h1);
        end else begin
          check("t5_segx", n, 32'(o_seg), 32'h3F);
        end
      end
    end

    // ---------------- 6: all-F stress ----------------
    i_digit      = 24'hFFFFFF;
    i_dp_mask    = 6'h3F;
    i_blink_mask = 6'h3F;
    i_lzs        = 1'b1;
    pulse_reset();
    for (int n = 1; n <= 400; n++) begin
      step();
      check("t6_onecold", n, 32'($countones(~o_seg_enb) <= 1), 32'h1);
      check("t6_enb", n, 32'(o_seg_enb), 32'(exp_enb(n)));
      if (!en(n)) begin
        check("t6_dead_seg", n, 32'(o_seg), 32'h00);
        check("t6_dead_dp",  n, 32'(o_seg_dp), 32'h0);
      end else if (fr(n) == 0) begin
        check("t6_f0_seg", n, 32'(o_seg), 32'h3F);
      end else begin
        check("t6_seg", n, 32'(o_seg), (bp(n) != 0) ? 32'h00 : 32'h71);
        check("t6_dp",  n, 32'(o_seg_dp), (bp(n) != 0) ? 32'h0 : 32'h1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Six-digit multiplexed 7-segment display scanner. It consumes the six 4-bit digit values produced by the counter stage (`i_digit`) and drives the shared segment bus (`o_seg`, `o_seg_dp`) plus per-digit enables (`o_seg_enb`) of the board display. It sits directly downstream of the counter/BCD stage, and its outputs go to the top-level display pins. Features:
- per-frame input snapshot (no tearing);
- inter-digit dead time (ghost suppression);
- per-digit decimal-point and blink masks;
- optional leading-zero suppression.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clocks per digit slot (1 kHz slot rate at 50 MHz); legal range ≥ 4.
- `DEAD_CYC`, 2500: clocks at the start of each slot with all digits disabled; must be < `SCAN_DIV`.
- `BLINK_DIV`, 500: slots per blink half-period (500 ms at defaults); must be ≥ 1.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: asynchronous reset, active-high.
- `i_digit` in 24: six 4-bit digit values; [3:0] is digit 0 (rightmost), [23:20] is digit 5.
- `i_dp_mask` in 6: bit k=1 lights the decimal point of digit k.
- `i_blink_mask` in 6: bit k=1 makes digit k blink.
- `i_lzs` in 1: 1 enables leading-zero suppression.
- `o_seg` out 7: segments {g,f,e,d,c,b,a}. 1 = lit.
- `o_seg_dp` out 1: decimal point. 1 = lit.
- `o_seg_enb` out 6: digit enables, active-low one-cold. Bit k=0 drives digit k.

## Operation
- **Prescaler** `pcnt`: counts 0..`SCAN_DIV`-1 every clock and wraps to 0.
- **Slot index** `idx`: 0..5. Advances on the clock where `pcnt`==`SCAN_DIV`-1. Wraps 5→0.
- **Snapshot**: `i_digit`, `i_dp_mask`, `i_blink_mask` and `i_lzs` are registered only on the clock where `idx` wraps 5→0. Input changes mid-frame are not visible until the next frame.
- **Blink**:
  - A slot-tick counter counts 0..`BLINK_DIV`-1.
  - At its terminal count, `blink_ph` toggles.
  - While `blink_ph`=1, digits with a blink-mask bit set are blanked.
- **Leading-zero suppression** (snapshot `i_lzs`=1):
  - Digit k (k=5 down to 1) is blanked if it and every digit above it equal 0.
  - Digit 0 is never blanked by LZS.
  - The decimal point of a blanked digit is still driven from the mask.
- **Blank digit**: `o_seg`=0. `o_seg_enb` still selects the digit. `o_seg_dp` comes from the mask, except under blink, where the dp is also 0.
- **Decode**, hex: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- **Dead time**: while `pcnt` < `DEAD_CYC`, the outputs are `o_seg_enb`=6'h3F, `o_seg`=0, `o_seg_dp`=0.
- **Otherwise**: `o_seg_enb` = ~(1<<`idx`), with `o_seg` and `o_seg_dp` from the snapshot digit `idx`.

## Timing
- **Reset values**:
  - State: `pcnt`=0, `idx`=0, `blink_ph`=0, blink counter=0, snapshot=all zero (LZS off).
  - Outputs: `o_seg`=0, `o_seg_dp`=0, `o_seg_enb`=6'h3F.
- **Output latency**: all outputs are registered and reflect (`pcnt`, `idx`, snapshot) with one clock of latency.
- **First frame after reset**: shows snapshot zeros, i.e. "000000" with no dp. First real inputs appear after the first 5→0 wrap, which is 6·`SCAN_DIV` clocks after reset release.
- **Slot length**: each slot lasts exactly `SCAN_DIV` clocks, of which `SCAN_DIV`-`DEAD_CYC` are enabled. Frame = 6·`SCAN_DIV` clocks.
- **Simultaneous wrap**: when the `idx` wrap and a blink toggle fall on the same clock, both take effect; the new frame uses the new `blink_ph`.
- **Reset mid-slot**: asynchronous. Outputs go to reset values immediately, without waiting for a clock edge. Scan restarts at slot 0 after release.
- **Enable invariant**: at most one `o_seg_enb` bit is low on any cycle; `o_seg_enb` is never 6'h00.

## Test plan
Bench parameters: `SCAN_DIV`=8, `DEAD_CYC`=2, `BLINK_DIV`=4 unless stated.

1. **Reset**: assert `rst` mid-slot. Outputs go 0 / 0 / 6'h3F before the next clock edge. After release, slot 0 enable (6'h3E) first appears at clock 3.
2. **Scan and decode**: `i_digit`=24'h123456, masks=0, `i_lzs`=0. In frame 2, the slot k enabled windows give o_seg_enb=~(1<<k) with o_seg:
   - slot 0 → 7D
   - slot 1 → 6D
   - slot 2 → 66
   - slot 3 → 4F
   - slot 4 → 5B
   - slot 5 → 06

   Each window is 6 clocks long, preceded by 2 clocks of 6'h3F.
3. **Snapshot**: change `i_digit` from 24'h111111 to 24'h222222 during slot 2. o_seg stays 06 through slot 5 and becomes 5B from the next frame's slot 0.
4. **LZS + dp**: `i_digit`=24'h000105, `i_lzs`=1, `i_dp_mask`=6'b100001.
   - Digits 5, 4, 3 show o_seg=0; digit 5 has o_seg_dp=1.
   - Digit 2 shows 06, digit 1 shows 3F, digit 0 shows 6D with o_seg_dp=1.
5. **Blink**: `i_blink_mask`=6'b000001, digit 0=8. o_seg/o_seg_dp in slot 0:
   - 7F/mask for 4 slots, then 00/0 for 4 slots, alternating.
   - Digit 1 is unaffected.
6. **All-F stress**: `i_digit`=24'hFFFFFF, all masks set, long run. Check every clock:
   - o_seg_enb never has two zero bits;
   - o_seg=71 whenever a digit is enabled and `blink_ph`=0.
